multicycle_control_unit: RTL
============================

# multicycle_control_unit

Multicycle control FSM for the MIPS datapath. It replaces the single-cycle combinational decoder with a Moore-style state machine that sequences fetch, decode, execute, memory and writeback over several cycles. It adds a memory-ready handshake so instruction/data memory may insert wait states, and provides parameter-selectable `addi`/`j` support with illegal-opcode reporting. It sits beside the shared-memory multicycle datapath and drives every mux select and write strobe in it.

## Interface
Parameters:
- `ALU_CTRL_WIDTH`, 3, width of `ALU_control`.
- `ENABLE_ADDI`, 1, when 0 opcode `addi` is treated as illegal.
- `ENABLE_JUMP`, 1, when 0 opcode `j` is treated as illegal.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
  - `clk` input 1: the single clock.
  - `rst` input 1: synchronous, active-high reset.
- Decode and handshake inputs:
  - `op` input 6: instruction opcode field.
  - `funct` input 6: R-type function field.
  - `zero` input 1: ALU zero flag.
  - `mem_ready` input 1: memory completes the current access this cycle.
- Memory-side outputs:
  - `mem_req` output 1: memory access request.
  - `iord` output 1: memory address select, 0 = PC, 1 = ALU register.
  - `mem_write` output 1: data memory write strobe.
  - `ir_write` output 1: instruction register load.
- Register-file outputs:
  - `reg_dst` output 1: write address select, 0 = rt, 1 = rd.
  - `mem_to_reg` output 1: writeback select, 0 = ALU register, 1 = data register.
  - `reg_write` output 1: register file write enable.
- ALU and PC outputs:
  - `ALU_src_a` output 1: ALU A select, 0 = PC, 1 = A register.
  - `ALU_src_b` output 2: ALU B select, 00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
  - `ALU_control` output `ALU_CTRL_WIDTH`: ALU operation.
  - `pc_src` output 2: next-PC select, 00 = ALU result, 01 = ALU register, 10 = jump target.
  - `pc_en` output 1: PC load, equal to `pc_write | (branch & zero)`.
- Status outputs:
  - `illegal_op` output 1: one-cycle pulse on an undefined opcode or funct.
  - `state` output 4: current state, for debug.

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- R-type funct to ALU code:
  - add 100000 → 010.
  - sub 100010 → 110.
  - and 100100 → 000.
  - or 100101 → 001.
  - slt 101010 → 111.
- States and their asserted outputs. Any output not listed for a state is 0.
  - FETCH: `mem_req`=1, `iord`=0, `ALU_src_a`=0, `ALU_src_b`=01, ALU add (010), `pc_src`=00. `ir_write` and `pc_write` assert only when `mem_ready`=1. Stay in FETCH while `mem_ready`=0; otherwise go to DECODE.
  - DECODE: `ALU_src_a`=0, `ALU_src_b`=11, add (branch target is precomputed).
    - lw/sw → MEMADR.
    - R-type → EXECUTE.
    - beq → BRANCH.
    - addi → ADDIEX.
    - j → JUMP.
    - Anything else → FETCH, with `illegal_op`=1.
  - MEMADR: `ALU_src_a`=1, `ALU_src_b`=10, add. lw → MEMREAD; sw → MEMWRITE.
  - MEMREAD: `mem_req`=1, `iord`=1. Hold until `mem_ready`=1, then go to MEMWB.
  - MEMWB: `reg_dst`=0, `mem_to_reg`=1, `reg_write`=1. Next state FETCH.
  - MEMWRITE: `mem_req`=1, `iord`=1, `mem_write`=1 every cycle in the state. Hold until `mem_ready`=1, then go to FETCH.
  - EXECUTE: `ALU_src_a`=1, `ALU_src_b`=00, ALU code from funct. On an undefined funct, go to FETCH with `illegal_op`=1 and no writeback; otherwise go to ALUWB.
  - ALUWB: `reg_dst`=1, `mem_to_reg`=0, `reg_write`=1. Next state FETCH.
  - BRANCH: `ALU_src_a`=1, `ALU_src_b`=00, sub (110), `pc_src`=01, `branch`=1. Next state FETCH.
  - ADDIEX: `ALU_src_a`=1, `ALU_src_b`=10, add. Next state ADDIWB.
  - ADDIWB: `reg_dst`=0, `mem_to_reg`=0, `reg_write`=1. Next state FETCH.
  - JUMP: `pc_src`=10, `pc_write`=1. Next state FETCH.
- The opcode for a disabled parameter option follows the illegal-opcode path.

## Timing
- State register updates on the rising edge of `clk`. All outputs are combinational from the state; FETCH strobes are additionally gated by `mem_ready`.
- Cycles per instruction with zero wait states:
  - lw 5.
  - sw 4.
  - R-type 4.
  - addi 4.
  - beq 3.
  - j 3.
  - Illegal 2.
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. No strobe other than `mem_req`/`mem_write` asserts during a wait cycle.
- Reset:
  - `rst`=1 at an edge forces state to FETCH from any state, aborting the instruction in progress.
  - While `rst`=1, these are forced to 0: `mem_req`, `mem_write`, `ir_write`, `reg_write`, `pc_en`, `illegal_op`.
  - While `rst`=1, the remaining outputs take FETCH values: `ALU_src_b`=01, `ALU_control`=010, all others 0.
  - `state` reads 0 (FETCH).
- `illegal_op` is high for exactly the one cycle spent in DECODE or EXECUTE that detects the fault.

## Structure
- Package `mips_pkg`:
  - opcode and funct constants.
  - ALU codes.
  - `ALU_src_b`/`pc_src` encodings.
  - state enum (4-bit, FETCH = 0).
- Sub-module `alu_decoder`: combinational mapping of state class and funct to `ALU_control` and funct-illegal.

## Test plan
- Reset, then lw with `mem_ready` held at 1 → states FETCH→DECODE→MEMADR→MEMREAD→MEMWB, with `reg_write`=1 and `mem_to_reg`=1 in cycle 5.
- sw with `mem_ready` low for 3 cycles in MEMWRITE → `mem_write` high for 4 cycles, then FETCH.
- beq: with `zero`=1, `pc_en`=1 and `pc_src`=01 in BRANCH; with `zero`=0, `pc_en`=0.
- R-type funct 101010 → `ALU_control`=111 in EXECUTE. funct 111111 → `illegal_op` pulse, no `reg_write`, return to FETCH.
- With `ENABLE_JUMP`=0, op 000010 → `illegal_op`=1 in DECODE. With `ENABLE_JUMP`=1 → JUMP, `pc_src`=10, `pc_en`=1.
- `rst` asserted in MEMREAD → next state FETCH, all strobes 0 while `rst` is high.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, functs, ALU codes, mux encodings and state enum for the multicycle control unit
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'd0,
    ALU_OP_SUB   = 2'd1,
    ALU_OP_FUNCT = 2'd2
  } alu_op_t;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps the state's ALU class and funct to an ALU code and a funct-illegal flag
module alu_decoder
  import mips_pkg::*;
#(
  parameter int ALU_CTRL_WIDTH = 3
) (
  input  alu_op_t                   alu_op,
  input  logic [5:0]                funct,
  output logic [ALU_CTRL_WIDTH-1:0] alu_control,
  output logic                      funct_illegal
);

  logic [2:0] code;

  always_comb begin
    code          = ALU_ADD;
    funct_illegal = 1'b0;
    case (alu_op)
      ALU_OP_SUB: code = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct)
          FUNCT_ADD: code = ALU_ADD;
          FUNCT_SUB: code = ALU_SUB;
          FUNCT_AND: code = ALU_AND;
          FUNCT_OR:  code = ALU_OR;
          FUNCT_SLT: code = ALU_SLT;
          default: begin
            code          = ALU_ADD;
            funct_illegal = 1'b1;
          end
        endcase
      end
      default: code = ALU_ADD;
    endcase
    alu_control = ALU_CTRL_WIDTH'(code);
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - Moore multicycle MIPS control FSM with memory-ready wait states
module multicycle_control_unit
  import mips_pkg::*;
#(
  parameter int ALU_CTRL_WIDTH = 3,
  parameter int ENABLE_ADDI    = 1,
  parameter int ENABLE_JUMP    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [5:0]                op,
  input  logic [5:0]                funct,
  input  logic                      zero,
  input  logic                      mem_ready,
  output logic                      mem_req,
  output logic                      iord,
  output logic                      mem_write,
  output logic                      ir_write,
  output logic                      reg_dst,
  output logic                      mem_to_reg,
  output logic                      reg_write,
  output logic                      ALU_src_a,
  output logic [1:0]                ALU_src_b,
  output logic [ALU_CTRL_WIDTH-1:0] ALU_control,
  output logic [1:0]                pc_src,
  output logic                      pc_en,
  output logic                      illegal_op,
  output logic [3:0]                state
);

  state_t  state_q, state_d;
  alu_op_t alu_op;
  logic    funct_illegal;
  logic    pc_write;
  logic    branch;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // ALU class is kept apart from the main decode so funct_illegal never loops back into it.
  always_comb begin
    alu_op = ALU_OP_ADD;
    if (!rst) begin
      case (state_q)
        S_EXECUTE: alu_op = ALU_OP_FUNCT;
        S_BRANCH:  alu_op = ALU_OP_SUB;
        default:   alu_op = ALU_OP_ADD;
      endcase
    end
  end

  alu_decoder #(.ALU_CTRL_WIDTH(ALU_CTRL_WIDTH)) u_alu_decoder (
    .alu_op        (alu_op),
    .funct         (funct),
    .alu_control   (ALU_control),
    .funct_illegal (funct_illegal)
  );

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    ALU_src_a  = 1'b0;
    ALU_src_b  = SRC_B_REG;
    pc_src     = PC_SRC_ALU;
    pc_write   = 1'b0;
    branch     = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALU_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALU_src_b = SRC_B_IMM_SH2;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI: begin
            if (ENABLE_ADDI != 0) state_d = S_ADDIEX;
            else begin
              state_d    = S_FETCH;
              illegal_op = 1'b1;
            end
          end
          OP_J: begin
            if (ENABLE_JUMP != 0) state_d = S_JUMP;
            else begin
              state_d    = S_FETCH;
              illegal_op = 1'b1;
            end
          end
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALU_src_a = 1'b1;
        ALU_src_b = SRC_B_IMM;
        if (op == OP_SW) state_d = S_MEMWRITE;
        else             state_d = S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        ALU_src_a = 1'b1;
        if (funct_illegal) begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d = S_ALUWB;
        end
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALU_src_a = 1'b1;
        pc_src    = PC_SRC_ALUOUT;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        ALU_src_a = 1'b1;
        ALU_src_b = SRC_B_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = PC_SRC_JUMP;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset presents an idle FETCH: address path at PC+4, every strobe off.
    if (rst) begin
      state_d    = S_FETCH;
      mem_req    = 1'b0;
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      ALU_src_a  = 1'b0;
      ALU_src_b  = SRC_B_FOUR;
      pc_src     = PC_SRC_ALU;
      pc_write   = 1'b0;
      branch     = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign pc_en = pc_write | (branch & zero);
  assign state = rst ? 4'd0 : state_q;

endmodule
